serializer_tx: RTL and testbench
================================

# serializer_tx

Parallel-to-serial transmitter that produces the LSB-first serial bit stream our deserializing receiver consumes on its `inputdata_i` line. A word is loaded through a valid/ready handshake. It is shifted out one bit per `CLKS_PER_BIT` clocks on `data_o`, with `ena_o` qualifying each valid bit. It sits between the parallel word source and the serial link, and doubles as the stimulus generator for receiver benches.

## Interface
- `DATA_W`, 10, word width in bits (≥2).
- `CLKS_PER_BIT`, 1, clocks each bit is held on `data_o` (≥1).

- `clk_i`  in  1  system clock, all logic on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `data_i`  in  DATA_W  parallel word to transmit.
- `valid_i`  in  1  `data_i` valid.
- `ready_o`  out  1  block can accept a word this cycle.
- `data_o`  out  1  serial data, LSB first.
- `ena_o`  out  1  high while `data_o` carries a valid bit.
- `busy_o`  out  1  word in flight.
- `done_o`  out  1  one-cycle pulse after the last bit of a word.

## Operation
- FSM states: IDLE, SHIFT, and PARITY (PARITY only with the macro).
- IDLE:
  - `ready_o`=1, `ena_o`=0, `data_o`=0, `busy_o`=0.
  - On an edge with `valid_i && ready_o`, capture `data_i` into the shift register, clear the bit and divider counters, and go to SHIFT.
- SHIFT:
  - `data_o` = shreg[0], `ena_o`=1, `busy_o`=1, `ready_o`=0.
  - The divider counts 0..CLKS_PER_BIT-1. At terminal count, shift right and increment the bit counter.
  - After bit DATA_W-1 completes, go to PARITY if the macro is defined, else go to IDLE.
- Exit to IDLE: assert `done_o` for exactly one cycle, set `ready_o`=1, and drive `data_o`=0, `ena_o`=0.
- `valid_i` and `data_i` are ignored while `ready_o`=0. The captured word is immune to later `data_i` changes.
- Counter widths: bit counter $clog2(DATA_W+2), divider $clog2(CLKS_PER_BIT+1). No wrap beyond terminal values.
- All outputs are registered. No combinational path from inputs to outputs.

## Timing
- Reset values: `ready_o`=0, `data_o`=0, `ena_o`=0, `busy_o`=0, `done_o`=0, FSM=IDLE.
  - `ready_o` rises on the first clock edge after `rst_i` deasserts.
- Latency: bit 0 appears on `data_o`/`ena_o` on the edge that accepts the word (visible the cycle after `valid_i && ready_o`).
- Each bit is held for exactly CLKS_PER_BIT cycles. A word occupies DATA_W×CLKS_PER_BIT cycles with `ena_o`=1, plus CLKS_PER_BIT for parity when enabled.
- `done_o` and `ready_o` rise on the same edge `ena_o` falls.
- Back-to-back words with `valid_i` held high: exactly one cycle with `ena_o`=0 between words, because the accept happens in the IDLE cycle.
- Reset mid-word:
  - All outputs return to reset values immediately (asynchronous).
  - The word is discarded and no `done_o` is issued.
  - After release, the next word restarts at bit 0.
- CLKS_PER_BIT=1: `data_o` changes every cycle. The divider is constant 0.

## Configuration
- `SERIALIZER_TX_PARITY_EN` defined:
  - After the MSB, one extra bit is sent, the XOR of the captured word (even parity).
  - `ena_o` stays high for it, for CLKS_PER_BIT cycles.
  - `done_o` follows the parity bit.
- Undefined: no PARITY state. The frame is exactly DATA_W bits.

## Test plan
- Reset: hold `rst_i`=0 for 2 cycles with `valid_i`=1 → all outputs 0. `ready_o`=1 one edge after release, and no word is accepted during reset.
- Single word, CLKS_PER_BIT=1, `data_i`=10'b1100011011 → `data_o` = 1,1,0,1,1,0,0,0,1,1 over 10 consecutive `ena_o` cycles, then `done_o` pulse. With the macro, an 11th bit 0 (six ones) precedes `done_o`.
- Back-to-back: words 10'h3FF then 10'h000 with `valid_i` held → 10 ones, exactly one `ena_o`=0 gap cycle, then 10 zeros. Two `done_o` pulses 11 cycles apart.
- Divider: CLKS_PER_BIT=4, `data_i`=10'h001 → `data_o`=1 for 4 cycles, then 0 for 36 cycles, with `ena_o` high for 40 cycles.
- Busy-ignore: change `data_i` to 10'h155 and pulse `valid_i` during the SHIFT of 10'h2AA → the serial output is exactly 10'h2AA and no extra word is sent.
- Mid-word reset: assert `rst_i`=0 at bit 5 → `ena_o` and `data_o` drop to 0 immediately with no `done_o`. After release, a new word is sent from bit 0 correctly.

Source files
------------

// File: rtl/serializer_tx.sv
// LSB-first parallel-to-serial transmitter with valid/ready load and per-bit clock divider.
// Define SERIALIZER_TX_PARITY_EN to append an even-parity bit after the MSB.
module serializer_tx #(
  parameter int DATA_W       = 10,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              data_o,
  output logic              ena_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int BW = $clog2(DATA_W + 2);
  localparam int DW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef SERIALIZER_TX_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]        state;
  // Bit 0 goes straight to data_o on accept, so only the upper bits are held here.
  logic [DATA_W-2:0] shreg;
  logic [BW-1:0]     bitcnt;
  logic [DW-1:0]     divcnt;
`ifdef SERIALIZER_TX_PARITY_EN
  logic              par;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      shreg   <= '0;
      bitcnt  <= '0;
      divcnt  <= '0;
      ready_o <= 1'b0;
      data_o  <= 1'b0;
      ena_o   <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
`ifdef SERIALIZER_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          ready_o <= 1'b1;
          if (valid_i && ready_o) begin
            shreg   <= data_i[DATA_W-1:1];
            data_o  <= data_i[0];
            bitcnt  <= '0;
            divcnt  <= '0;
            ena_o   <= 1'b1;
            busy_o  <= 1'b1;
            ready_o <= 1'b0;
            state   <= SHIFT;
`ifdef SERIALIZER_TX_PARITY_EN
            par     <= ^data_i;
`endif
          end
        end
        SHIFT: begin
          if (divcnt == DIV_LAST) begin
            divcnt <= '0;
            if (bitcnt == BIT_LAST) begin
`ifdef SERIALIZER_TX_PARITY_EN
              data_o <= par;
              bitcnt <= bitcnt + 1'b1;
              state  <= PARITY;
`else
              state   <= IDLE;
              done_o  <= 1'b1;
              ready_o <= 1'b1;
              data_o  <= 1'b0;
              ena_o   <= 1'b0;
              busy_o  <= 1'b0;
`endif
            end else begin
              data_o <= shreg[0];
              shreg  <= shreg >> 1;
              bitcnt <= bitcnt + 1'b1;
            end
          end else begin
            divcnt <= divcnt + 1'b1;
          end
        end
`ifdef SERIALIZER_TX_PARITY_EN
        PARITY: begin
          if (divcnt == DIV_LAST) begin
            divcnt  <= '0;
            state   <= IDLE;
            done_o  <= 1'b1;
            ready_o <= 1'b1;
            data_o  <= 1'b0;
            ena_o   <= 1'b0;
            busy_o  <= 1'b0;
          end else begin
            divcnt <= divcnt + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serializer_tx.sv
// Directed bench for serializer_tx: one instance at CLKS_PER_BIT=1, one at 4.
// Expected bit streams are written out by hand in transmission order.
module tb_serializer_tx;

`ifdef SERIALIZER_TX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int FLEN = 10 + PAR_EN;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] din;
  logic       valid1, valid4;
  logic       r1, d1, e1, b1, dn1;
  logic       r4, d4, e4, b4, dn4;
  logic       cur;
  logic       o_ready, o_data, o_ena, o_busy, o_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serializer_tx #(.DATA_W(10), .CLKS_PER_BIT(1)) u1 (
    .clk_i(clk), .rst_i(rst_n), .data_i(din), .valid_i(valid1),
    .ready_o(r1), .data_o(d1), .ena_o(e1), .busy_o(b1), .done_o(dn1)
  );

  serializer_tx #(.DATA_W(10), .CLKS_PER_BIT(4)) u4 (
    .clk_i(clk), .rst_i(rst_n), .data_i(din), .valid_i(valid4),
    .ready_o(r4), .data_o(d4), .ena_o(e4), .busy_o(b4), .done_o(dn4)
  );

  always_comb begin
    o_ready = cur ? r4  : r1;
    o_data  = cur ? d4  : d1;
    o_ena   = cur ? e4  : e1;
    o_busy  = cur ? b4  : b1;
    o_done  = cur ? dn4 : dn1;
  end

  typedef struct {
    logic       sel;   // 0: CLKS_PER_BIT=1, 1: CLKS_PER_BIT=4
    logic [9:0] word;
    logic [0:9] seq;   // bits in the order they appear on data_o
    logic       par;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_valid(input logic v);
    if (cur) valid4 = v;
    else     valid1 = v;
  endtask

  // Sends one word and checks every cycle of the frame plus the done pulse.
  // glitch_bit >= 0 pulses valid with 10'h155 while that bit is on the line.
  task automatic xmit(input logic sel, input logic [9:0] w, input logic [0:9] seq,
                      input logic par, input int glitch_bit);
    int clks;
    int n;
    bit gl;
    cur  = sel;
    clks = sel ? 4 : 1;
    gl   = 1'b0;
    n    = 0;
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_word", {31'd0, o_ready}, 32'd1);
    din = w;
    set_valid(1'b1);
    @(negedge clk);
    set_valid(1'b0);
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < clks; c++) begin
        chk("bit_ena",   {31'd0, o_ena},   32'd1);
        chk("bit_data",  {31'd0, o_data},  {31'd0, seq[i]});
        chk("bit_busy",  {31'd0, o_busy},  32'd1);
        chk("bit_ready", {31'd0, o_ready}, 32'd0);
        chk("bit_done",  {31'd0, o_done},  32'd0);
        if (i == glitch_bit && c == 0) begin
          din = 10'h155;
          set_valid(1'b1);
          gl = 1'b1;
        end
        @(negedge clk);
        if (gl) begin
          set_valid(1'b0);
          gl = 1'b0;
        end
      end
    end
    if (PAR_EN == 1) begin
      for (int c = 0; c < clks; c++) begin
        chk("par_ena",  {31'd0, o_ena},  32'd1);
        chk("par_data", {31'd0, o_data}, {31'd0, par});
        @(negedge clk);
      end
    end
    chk("end_done",  {31'd0, o_done},  32'd1);
    chk("end_ena",   {31'd0, o_ena},   32'd0);
    chk("end_data",  {31'd0, o_data},  32'd0);
    chk("end_ready", {31'd0, o_ready}, 32'd1);
    chk("end_busy",  {31'd0, o_busy},  32'd0);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, o_done}, 32'd0);
    chk("idle_ena",       {31'd0, o_ena},  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b0, 10'b1100011011, 10'b1101100011, 1'b0};
    vt[1] = '{1'b0, 10'h2AA,        10'b0101010101, 1'b1};
    vt[2] = '{1'b0, 10'h200,        10'b0000000001, 1'b1};
    vt[3] = '{1'b0, 10'h0F3,        10'b1100111100, 1'b0};
    vt[4] = '{1'b1, 10'h001,        10'b1000000000, 1'b1};
    vt[5] = '{1'b1, 10'h3FF,        10'b1111111111, 1'b0};

    // Reset with valid held high: nothing may be accepted.
    cur    = 1'b0;
    rst_n  = 1'b0;
    din    = 10'h3FF;
    valid1 = 1'b1;
    valid4 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready1", {27'd0, r1, d1, e1, b1, dn1}, 32'd0);
    chk("rst_ready4", {27'd0, r4, d4, e4, b4, dn4}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst1", {27'd0, r1, d1, e1, b1, dn1}, 32'h10);
    chk("post_rst4", {27'd0, r4, d4, e4, b4, dn4}, 32'h10);
    valid1 = 1'b0;
    valid4 = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++)
      xmit(vt[v].sel, vt[v].word, vt[v].seq, vt[v].par, -1);

    // Back-to-back with valid held: one gap cycle, done pulses FLEN+1 apart.
    cur    = 1'b0;
    din    = 10'h3FF;
    valid1 = 1'b1;
    @(negedge clk);
    din = 10'h000;
    for (int k = 0; k < 2 * FLEN + 2; k++) begin
      chk("b2b_ena",  {31'd0, e1},  (k == FLEN || k == 2 * FLEN + 1) ? 32'd0 : 32'd1);
      chk("b2b_data", {31'd0, d1},  (k < 10) ? 32'd1 : 32'd0);
      chk("b2b_done", {31'd0, dn1}, (k == FLEN || k == 2 * FLEN + 1) ? 32'd1 : 32'd0);
      if (k == FLEN + 1) valid1 = 1'b0;
      @(negedge clk);
    end
    chk("b2b_idle_after", {31'd0, e1}, 32'd0);
    @(negedge clk);

    // Busy-ignore: a new word offered mid-frame must not disturb or follow 10'h2AA.
    xmit(1'b0, 10'h2AA, 10'b0101010101, 1'b1, 3);
    for (int k = 0; k < 3; k++) begin
      chk("no_extra_word", {31'd0, e1}, 32'd0);
      @(negedge clk);
    end

    // Mid-word reset at bit 5.
    cur    = 1'b0;
    din    = 10'h0F3;
    valid1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_bit5", {30'd0, e1, d1}, 32'h3);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {27'd0, r1, d1, e1, b1, dn1}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("midrst_no_done", {31'd0, dn1}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_release", {27'd0, r1, d1, e1, b1, dn1}, 32'h10);
    xmit(1'b0, 10'h0F3, 10'b1100111100, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
